// File: rtl/adxl345_pkg.sv
// ADXL345 responder shared definitions: register map, reset values, FSM states.
// Also used by the accelerometer controller bench.
package adxl345_pkg;

   localparam int unsigned ADDR_W         = 6;
   localparam int unsigned DATA_W         = 8;
   localparam int unsigned SAMPLE_W       = 16;
   localparam int unsigned NUM_AXIS_BYTES = 6;

   localparam logic [ADDR_W-1:0] ADDR_DEVID       = 6'h00;
   localparam logic [ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
   localparam logic [ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
   localparam logic [ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
   localparam logic [ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
   localparam logic [ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

   localparam logic [DATA_W-1:0] BW_RATE_RST     = 8'h0A;
   localparam logic [DATA_W-1:0] POWER_CTL_RST   = 8'h00;
   localparam logic [DATA_W-1:0] DATA_FORMAT_RST = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } spi_resp_state_t;

   // ADXL345 command byte layout
   typedef struct packed {
      logic              rw;    // 1 = read
      logic              mb;    // multi-byte, auto-increment address
      logic [ADDR_W-1:0] addr;
   } spi_cmd_t;

   // Only the three configuration registers accept writes
   function automatic logic is_writable(input logic [ADDR_W-1:0] a);
      return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) || (a == ADDR_DATA_FORMAT);
   endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// 4-wire SPI bus between an initiator (master) and the ADXL345 responder (slave).
//   spi_sclk/spi_mosi/spi_cs : initiator -> responder
//   spi_miso/miso_oe         : responder -> initiator / pad
interface adxl345_spi_responder_if;

   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs;
   logic spi_miso;
   logic miso_oe;

   modport master (
      output spi_sclk,
      output spi_mosi,
      output spi_cs,
      input  spi_miso,
      input  miso_oe
   );

   modport slave (
      input  spi_sclk,
      input  spi_mosi,
      input  spi_cs,
      output spi_miso,
      output miso_oe
   );

endinterface

// File: rtl/spi_pin_sync.sv
// SPI pin synchronisers with registered edge detect.
//   sys_clk, sys_rst           : clock, async active-high reset
//   spi_sclk/spi_mosi/spi_cs   : raw pins
//   sclk_rise/sclk_fall        : one-cycle pulses, SYNC_STAGES+1 cycles after the pin edge
//   cs_rise/cs_fall            : same for chip select
//   mosi_s                     : synchronised MOSI aligned with the sclk edge pulses
module spi_pin_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic spi_sclk,
   input  logic spi_mosi,
   input  logic spi_cs,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_rise,
   output logic cs_fall,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic sclk_prev_q, sclk_prev_d;
   logic cs_prev_q,   cs_prev_d;
   logic sclk_rise_q, sclk_rise_d;
   logic sclk_fall_q, sclk_fall_d;
   logic cs_rise_q,   cs_rise_d;
   logic cs_fall_q,   cs_fall_d;
   logic mosi_q,      mosi_d;
   logic sclk_lvl, cs_lvl;

   // Shift chains; the truncating cast drops the oldest stage
   always_comb begin
      sclk_sync_d = SYNC_STAGES'({sclk_sync_q, spi_sclk});
      mosi_sync_d = SYNC_STAGES'({mosi_sync_q, spi_mosi});
      cs_sync_d   = SYNC_STAGES'({cs_sync_q, spi_cs});
      sclk_lvl    = sclk_sync_q[SYNC_STAGES-1];
      cs_lvl      = cs_sync_q[SYNC_STAGES-1];
      sclk_prev_d = sclk_lvl;
      cs_prev_d   = cs_lvl;
      sclk_rise_d = sclk_lvl & ~sclk_prev_q;
      sclk_fall_d = ~sclk_lvl & sclk_prev_q;
      cs_rise_d   = cs_lvl & ~cs_prev_q;
      cs_fall_d   = ~cs_lvl & cs_prev_q;
      mosi_d      = mosi_sync_q[SYNC_STAGES-1];
   end

   // SCLK resets to its idle-high level. CS resets low so that a chip select
   // already asserted when reset releases never produces a falling edge: the
   // responder stays out of that transaction until CS has been seen high.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sclk_sync_q <= '1;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b1;
         cs_prev_q   <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_fall_q   <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
         cs_rise_q   <= cs_rise_d;
         cs_fall_q   <= cs_fall_d;
         mosi_q      <= mosi_d;
      end
   end

   assign sclk_rise = sclk_rise_q;
   assign sclk_fall = sclk_fall_q;
   assign cs_rise   = cs_rise_q;
   assign cs_fall   = cs_fall_q;
   assign mosi_s    = mosi_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 4-wire SPI (mode 3) register-interface emulator, oversampled on sys_clk.
//   sys_clk, sys_rst             : clock, async active-high reset
//   spi                          : SPI bus (slave modport)
//   x/y/z_sample, sample_valid   : axis data source, loads live data registers
//   bw_rate/power_ctl/data_format: configuration registers 0x2C/0x2D/0x31
//   wr_strobe, wr_addr           : pulse and address of each committed write
module adxl345_spi_responder
   import adxl345_pkg::*;
#(
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] DEVID_VALUE = 8'hE5
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   adxl345_spi_responder_if.slave spi,
   input  logic [SAMPLE_W-1:0] x_sample,
   input  logic [SAMPLE_W-1:0] y_sample,
   input  logic [SAMPLE_W-1:0] z_sample,
   input  logic                sample_valid,
   output logic [DATA_W-1:0]   bw_rate,
   output logic [DATA_W-1:0]   power_ctl,
   output logic [DATA_W-1:0]   data_format,
   output logic                wr_strobe,
   output logic [ADDR_W-1:0]   wr_addr
);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .spi_sclk  (spi.spi_sclk),
      .spi_mosi  (spi.spi_mosi),
      .spi_cs    (spi.spi_cs),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_rise   (cs_rise),
      .cs_fall   (cs_fall),
      .mosi_s    (mosi_s)
   );

   spi_resp_state_t state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-2:0] shift_in_q, shift_in_d;
   logic [DATA_W-1:0] shift_out_q, shift_out_d;
   spi_cmd_t          cmd_q, cmd_d;
   logic              miso_q, miso_d;
   logic              miso_oe_q, miso_oe_d;
   logic [NUM_AXIS_BYTES-1:0][DATA_W-1:0] live_q, live_d;
   logic [NUM_AXIS_BYTES-1:0][DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] bw_rate_q, bw_rate_d;
   logic [DATA_W-1:0] power_ctl_q, power_ctl_d;
   logic [DATA_W-1:0] data_format_q, data_format_d;
   logic              wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

   logic [DATA_W-1:0] byte_in_c;
   logic [DATA_W-1:0] rd_data_c;

   // Read mux; axis data always comes from the transaction snapshot
   always_comb begin
      rd_data_c = '0;
      case (cmd_q.addr)
         ADDR_DEVID:       rd_data_c = DEVID_VALUE;
         ADDR_BW_RATE:     rd_data_c = bw_rate_q;
         ADDR_POWER_CTL:   rd_data_c = power_ctl_q;
         ADDR_DATA_FORMAT: rd_data_c = data_format_q;
         ADDR_DATAX0:      rd_data_c = shadow_q[0];
         ADDR_DATAX1:      rd_data_c = shadow_q[1];
         ADDR_DATAY0:      rd_data_c = shadow_q[2];
         ADDR_DATAY1:      rd_data_c = shadow_q[3];
         ADDR_DATAZ0:      rd_data_c = shadow_q[4];
         ADDR_DATAZ1:      rd_data_c = shadow_q[5];
         default:          rd_data_c = '0;
      endcase
   end

   // Next-state and datapath
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_in_d    = shift_in_q;
      shift_out_d   = shift_out_q;
      cmd_d         = cmd_q;
      miso_d        = miso_q;
      live_d        = live_q;
      shadow_d      = shadow_q;
      bw_rate_d     = bw_rate_q;
      power_ctl_d   = power_ctl_q;
      data_format_d = data_format_q;
      wr_strobe_d   = 1'b0;
      wr_addr_d     = wr_addr_q;
      byte_in_c     = {shift_in_q, mosi_s};

      if (sample_valid) begin
         live_d = {z_sample, y_sample, x_sample};
      end

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               shadow_d  = live_q;   // pre-update values even if sample_valid coincides
            end
         end

         ST_CMD: begin
            miso_d = 1'b0;
            if (sclk_rise) begin
               shift_in_d = byte_in_c[DATA_W-2:0];
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  cmd_d   = spi_cmd_t'(byte_in_c);
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            // First falling edge of each byte loads the register, later ones shift
            if (sclk_fall) begin
               if (cmd_q.rw) begin
                  if (bit_cnt_q == 3'd0) begin
                     miso_d      = rd_data_c[DATA_W-1];
                     shift_out_d = {rd_data_c[DATA_W-2:0], 1'b0};
                  end else begin
                     miso_d      = shift_out_q[DATA_W-1];
                     shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  miso_d = 1'b0;
               end
            end
            if (sclk_rise) begin
               shift_in_d = byte_in_c[DATA_W-2:0];
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (!cmd_q.rw && is_writable(cmd_q.addr)) begin
                     case (cmd_q.addr)
                        ADDR_BW_RATE:     bw_rate_d     = byte_in_c;
                        ADDR_POWER_CTL:   power_ctl_d   = byte_in_c;
                        ADDR_DATA_FORMAT: data_format_d = byte_in_c;
                        default:          ;
                     endcase
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = cmd_q.addr;
                  end
                  if (cmd_q.mb) begin
                     cmd_d.addr = cmd_q.addr + ADDR_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
         end
      endcase

      // CS deassertion aborts from any state; a partial byte is simply dropped
      if (cs_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end

      miso_oe_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         shift_in_q    <= '0;
         shift_out_q   <= '0;
         cmd_q         <= '0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         live_q        <= '0;
         shadow_q      <= '0;
         bw_rate_q     <= BW_RATE_RST;
         power_ctl_q   <= POWER_CTL_RST;
         data_format_q <= DATA_FORMAT_RST;
         wr_strobe_q   <= 1'b0;
         wr_addr_q     <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_in_q    <= shift_in_d;
         shift_out_q   <= shift_out_d;
         cmd_q         <= cmd_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         live_q        <= live_d;
         shadow_q      <= shadow_d;
         bw_rate_q     <= bw_rate_d;
         power_ctl_q   <= power_ctl_d;
         data_format_q <= data_format_d;
         wr_strobe_q   <= wr_strobe_d;
         wr_addr_q     <= wr_addr_d;
      end
   end

   assign spi.spi_miso = miso_q;
   assign spi.miso_oe  = miso_oe_q;
   assign bw_rate      = bw_rate_q;
   assign power_ctl    = power_ctl_q;
   assign data_format  = data_format_q;
   assign wr_strobe    = wr_strobe_q;
   assign wr_addr      = wr_addr_q;

endmodule
